// File: rtl/tpu_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tpu_seq_ctrl_if : host, operand/result buffer and array signals of the      |
// |                   matrix-multiply sequencer                                 |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface tpu_seq_ctrl_if #(
   parameter int N           = 4,
   parameter int DATA_W      = 8,
   parameter int COMPUTE_CYC = 3*N-2,
   parameter int PERF_W      = 16
);
   localparam int AW = $clog2(N*N);
   localparam int SW = $clog2(COMPUTE_CYC+1);

   logic              host_we;
   logic              host_sel_b;
   logic [AW-1:0]     host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              start;
   logic              host_ready;
   logic              busy;
   logic              done;
   logic              result_valid;
   logic              wr_err;
   logic              we_a;
   logic              we_b;
   logic [AW-1:0]     addr_a;
   logic [AW-1:0]     addr_b;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] wdata_b;
   logic              arr_clear;
   logic              arr_en;
   logic [SW-1:0]     arr_step;
   logic              capture_c;
   logic [PERF_W-1:0] perf_cycles;

   modport slave (
      input  host_we, host_sel_b, host_addr, host_wdata, start,
      output host_ready, busy, done, result_valid, wr_err,
             we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
             arr_clear, arr_en, arr_step, capture_c, perf_cycles
   );

   modport master (
      output host_we, host_sel_b, host_addr, host_wdata, start,
      input  host_ready, busy, done, result_valid, wr_err,
             we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
             arr_clear, arr_en, arr_step, capture_c, perf_cycles
   );
endinterface
`default_nettype wire

// File: rtl/tpu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tpu_seq_ctrl : gates host operand writes, then clears/runs/drains the       |
// |                systolic array and captures C. Optional: TPU_SEQ_PERF_EN     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tpu_seq_ctrl #(
   parameter int N           = 4,
   parameter int DATA_W      = 8,
   parameter int COMPUTE_CYC = 3*N-2,
   parameter int DRAIN_CYC   = 1,
   parameter int PERF_W      = 16
) (
   input  logic            clk,
   input  logic            rst,
   tpu_seq_ctrl_if.slave   bus
);
   localparam int AW = $clog2(N*N);
   localparam int SW = $clog2(COMPUTE_CYC+1);
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [SW-1:0] C_STEP_LAST  = SW'(COMPUTE_CYC-1);
   localparam logic [DW-1:0] C_DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC-1 : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [SW-1:0]     r_step;
   logic [DW-1:0]     r_dcnt;
   logic              w_ready;
   logic              w_busy;
   logic              w_clear;
   logic              w_en;
   logic              w_cap;
   logic              w_done;
   logic              w_wr_ok;
   logic              w_start_ok;
   logic              r_we_a;
   logic              r_we_b;
   logic [AW-1:0]     r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wr_err;
   logic              r_result_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_busy  = 1'b0;
      w_clear = 1'b0;
      w_en    = 1'b0;
      w_cap   = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.start) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_busy  = 1'b1;
            w_clear = 1'b1;
            w_next  = S_RUN;
         end
         S_RUN: begin
            w_busy = 1'b1;
            w_en   = 1'b1;
            if (r_step == C_STEP_LAST) w_next = (DRAIN_CYC == 0) ? S_CAPTURE : S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (r_dcnt == C_DRAIN_LAST) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_busy = 1'b1;
            w_cap  = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Both counters return to 0 on their last value, so they never wrap mid-phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step <= '0;
         r_dcnt <= '0;
      end else begin
         r_step <= (r_state == S_RUN   && r_step != C_STEP_LAST)  ? r_step + 1'b1 : '0;
         r_dcnt <= (r_state == S_DRAIN && r_dcnt != C_DRAIN_LAST) ? r_dcnt + 1'b1 : '0;
      end
   end

   assign w_wr_ok    = bus.host_we & w_ready;
   assign w_start_ok = bus.start & w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we_a         <= 1'b0;
         r_we_b         <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_wr_err       <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_we_a   <= w_wr_ok & ~bus.host_sel_b;
         r_we_b   <= w_wr_ok &  bus.host_sel_b;
         r_wr_err <= bus.host_we & ~w_ready;
         if (w_wr_ok) begin
            r_addr  <= bus.host_addr;
            r_wdata <= bus.host_wdata;
         end
         // New operands or a new run invalidate C before any capture can re-set it
         if (w_wr_ok || w_start_ok) r_result_valid <= 1'b0;
         else if (w_cap)            r_result_valid <= 1'b1;
      end
   end

`ifdef TPU_SEQ_PERF_EN
   localparam logic [PERF_W-1:0] C_PERF_MAX = '1;
   logic [PERF_W-1:0] r_perf_cnt;
   logic [PERF_W-1:0] r_perf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_cnt <= '0;
         r_perf     <= '0;
      end else begin
         if (w_busy)       r_perf_cnt <= (r_perf_cnt == C_PERF_MAX) ? r_perf_cnt : r_perf_cnt + 1'b1;
         else if (w_ready) r_perf_cnt <= '0;
         if (w_done)       r_perf     <= r_perf_cnt;
      end
   end
   assign bus.perf_cycles = r_perf;
`else
   assign bus.perf_cycles = '0;
`endif

   assign bus.host_ready   = w_ready;
   assign bus.busy         = w_busy;
   assign bus.done         = w_done;
   assign bus.result_valid = r_result_valid;
   assign bus.wr_err       = r_wr_err;
   assign bus.we_a         = r_we_a;
   assign bus.we_b         = r_we_b;
   assign bus.addr_a       = r_addr;
   assign bus.addr_b       = r_addr;
   assign bus.wdata_a      = r_wdata;
   assign bus.wdata_b      = r_wdata;
   assign bus.arr_clear    = w_clear;
   assign bus.arr_en       = w_en;
   assign bus.arr_step     = w_en ? r_step : '0;
   assign bus.capture_c    = w_cap;
endmodule
`default_nettype wire

// File: tb/tb_tpu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tpu_seq_ctrl : randomized scoreboard bench for tpu_seq_ctrl              |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_tpu_seq_ctrl;
   localparam int N      = 4;
   localparam int DATA_W = 8;
   localparam int C      = 3*N-2;
   localparam int D      = 1;
   localparam int PERF_W = 16;
   localparam int AW     = $clog2(N*N);
`ifdef TPU_SEQ_PERF_EN
   localparam int PERF_EXP = 1 + C + D + 1;
`else
   localparam int PERF_EXP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tpu_seq_ctrl_if #(.N(N), .DATA_W(DATA_W), .COMPUTE_CYC(C), .PERF_W(PERF_W)) bus ();

   tpu_seq_ctrl #(.N(N), .DATA_W(DATA_W), .COMPUTE_CYC(C), .DRAIN_CYC(D), .PERF_W(PERF_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { int e; bit sel; int addr; int data; } wr_t;
   wr_t wq[$];
   int  errq[$];
   int  capq[$];
   int  doneq[$];
   bit  clr_edge[int];

   int cyc       = 0;
   int s_last    = -1000;
   int idle_from = 0;
   int rv_exp    = 0;
   int perf_exp  = 0;
   int errors    = 0;
   int checks    = 0;
   bit mon_en    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Inputs for edge e = cyc+1; the model decides acceptance from when the last run ends
   task automatic drive(input bit we, input bit sel, input int addr, input int data, input bit st);
      int  e;
      bit  ready;
      wr_t w;
      @(posedge clk); #1;
      bus.host_we    = we;
      bus.host_sel_b = sel;
      bus.host_addr  = AW'(addr);
      bus.host_wdata = DATA_W'(data);
      bus.start      = st;
      e     = cyc + 1;
      ready = (e >= idle_from);
      if (we && ready) begin
         w.e = e; w.sel = sel; w.addr = addr; w.data = data;
         wq.push_back(w);
         clr_edge[e] = 1'b1;
      end else if (we) begin
         errq.push_back(e);
      end
      if (st && ready) begin
         s_last    = e;
         idle_from = e + C + D + 4;
         capq.push_back(e + C + D + 1);
         doneq.push_back(e + C + D + 2);
         clr_edge[e] = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (cyc + 1 < idle_from && k < 200) begin
         drive(1'b0, 1'b0, 0, 0, 1'b0);
         k++;
      end
      if (k >= 200) chk("wait_idle_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_host_ready", bus.host_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result_valid", bus.result_valid, 0);
      chk("rst_wr_err", bus.wr_err, 0);
      chk("rst_we_a", bus.we_a, 0);
      chk("rst_we_b", bus.we_b, 0);
      chk("rst_addr_a", bus.addr_a, 0);
      chk("rst_wdata_b", bus.wdata_b, 0);
      chk("rst_arr_clear", bus.arr_clear, 0);
      chk("rst_arr_en", bus.arr_en, 0);
      chk("rst_arr_step", bus.arr_step, 0);
      chk("rst_capture_c", bus.capture_c, 0);
      chk("rst_perf", bus.perf_cycles, 0);
   endtask

   task automatic model_reset();
      wq.delete(); errq.delete(); capq.delete(); doneq.delete();
      s_last = -1000; idle_from = 0; rv_exp = 0; perf_exp = 0;
   endtask

   always @(negedge clk) begin : monitor
      int  d;
      bit  ex;
      wr_t it;
      if (mon_en && !rst) begin
         d = cyc - s_last;
         chk("busy", bus.busy, (d >= 0 && d <= C+D+1) ? 1 : 0);
         chk("host_ready", bus.host_ready, (d >= 0 && d <= C+D+2) ? 0 : 1);
         chk("arr_clear", bus.arr_clear, (d == 0) ? 1 : 0);
         chk("arr_en", bus.arr_en, (d >= 1 && d <= C) ? 1 : 0);
         chk("arr_step", bus.arr_step, (d >= 1 && d <= C) ? d - 1 : 0);
         if (clr_edge.exists(cyc)) rv_exp = 0;
         else if (d == C+D+2)      rv_exp = 1;
         chk("result_valid", bus.result_valid, rv_exp);
         if (d == C+D+2) perf_exp = PERF_EXP;
         chk("perf_cycles", bus.perf_cycles, perf_exp);

         if (wq.size() > 0 && wq[0].e < cyc) begin chk("write_missing", 0, 1); void'(wq.pop_front()); end
         ex = (wq.size() > 0 && wq[0].e == cyc);
         if (ex) begin
            it = wq.pop_front();
            chk("we_a", bus.we_a, it.sel ? 0 : 1);
            chk("we_b", bus.we_b, it.sel ? 1 : 0);
            chk(it.sel ? "addr_b" : "addr_a", it.sel ? bus.addr_b : bus.addr_a, it.addr);
            chk(it.sel ? "wdata_b" : "wdata_a", it.sel ? bus.wdata_b : bus.wdata_a, it.data);
         end else if (bus.we_a || bus.we_b) begin
            chk("we_spurious", {bus.we_a, bus.we_b}, 0);
         end

         if (errq.size() > 0 && errq[0] < cyc) begin chk("wr_err_missing", 0, 1); void'(errq.pop_front()); end
         ex = (errq.size() > 0 && errq[0] == cyc);
         if (ex || bus.wr_err) chk("wr_err", bus.wr_err, ex);
         if (ex) void'(errq.pop_front());

         if (capq.size() > 0 && capq[0] < cyc) begin chk("capture_missing", 0, 1); void'(capq.pop_front()); end
         ex = (capq.size() > 0 && capq[0] == cyc);
         if (ex || bus.capture_c) chk("capture_c", bus.capture_c, ex);
         if (ex) void'(capq.pop_front());

         if (doneq.size() > 0 && doneq[0] < cyc) begin chk("done_missing", 0, 1); void'(doneq.pop_front()); end
         ex = (doneq.size() > 0 && doneq[0] == cyc);
         if (ex || bus.done) chk("done", bus.done, ex);
         if (ex) void'(doneq.pop_front());
      end
   end

   initial begin
      bus.host_we = 1'b0; bus.host_sel_b = 1'b0; bus.host_addr = '0;
      bus.host_wdata = '0; bus.start = 1'b0;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      mon_en = 1'b1;

      // Load A = identity, B = 1..16, then run
      for (int i = 0; i < N*N; i++) drive(1'b1, 1'b0, i, (i / N == i % N) ? 1 : 0, 1'b0);
      for (int i = 0; i < N*N; i++) drive(1'b1, 1'b1, i, i + 1, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      wait_idle();
      idle(2);
      chk("result_valid_after_run", bus.result_valid, 1);
      chk("perf_after_run", bus.perf_cycles, PERF_EXP);

      // Writes and start during RUN are dropped / ignored
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      idle(3);
      drive(1'b1, 1'b0, 3, 8'h55, 1'b1);
      drive(1'b1, 1'b1, 7, 8'hAA, 1'b0);
      wait_idle();

      // Start and write on the same edge in IDLE
      drive(1'b1, 1'b1, 15, 8'h7F, 1'b1);
      wait_idle();
      idle(1);

      // Reset while RUN is at step 5
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      while (cyc < s_last + 6) drive(1'b0, 1'b0, 0, 0, 1'b0);
      chk("step_before_rst", bus.arr_step, 5);
      #3 rst = 1'b1;
      bus.host_we = 1'b0; bus.start = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      @(posedge clk); #2 rst = 1'b0;
      idle(20);
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      wait_idle();
      idle(2);
      chk("result_valid_after_rerun", bus.result_valid, 1);

      // Random traffic
      for (int i = 0; i < 500; i++)
         drive($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)), $urandom_range(0, N*N-1),
               $urandom_range(0, 255), $urandom_range(0, 99) < 6);
      wait_idle();
      idle(3);

      chk("write_queue_drained", wq.size(), 0);
      chk("err_queue_drained", errq.size(), 0);
      chk("capture_queue_drained", capq.size(), 0);
      chk("done_queue_drained", doneq.size(), 0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
